// File: rtl/mem_port_arbiter.sv
// Two-master arbiter for one shared memory port: the D side has priority, and the
// I side is forced in after STARVE_LIMIT consecutive D grants while it waits.
module mem_port_arbiter #(
  parameter int BURST_LEN    = 8,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] I_ADDR,
  input  logic [1:0]  I_BURST,
  input  logic        I_REQ,
  input  logic        I_WRB,
  input  logic [31:0] I_WDATA,
  input  logic [3:0]  I_BSTROBE,
  output logic [31:0] I_RDATA,
  output logic        I_ACK,
  output logic        I_STALL,
  input  logic [31:0] D_ADDR,
  input  logic [1:0]  D_BURST,
  input  logic        D_REQ,
  input  logic        D_WRB,
  input  logic [31:0] D_WDATA,
  input  logic [3:0]  D_BSTROBE,
  output logic [31:0] D_RDATA,
  output logic        D_ACK,
  output logic        D_STALL,
  output logic [31:0] M_ADDR,
  output logic [1:0]  M_BURST,
  output logic        M_REQ,
  output logic        M_WRB,
  output logic [31:0] M_WDATA,
  output logic [3:0]  M_BSTROBE,
  input  logic [31:0] M_RDATA,
  input  logic        M_ACK,
  input  logic        M_STALL,
  output logic        gnt_i,
  output logic        gnt_d
);

  localparam int CW = $clog2(BURST_LEN) + 1;
  localparam int SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] TGT_BURST  = CW'(BURST_LEN);
  localparam logic [CW-1:0] TGT_SINGLE = CW'(1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, GNT_I, GNT_D} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] beat_cnt, beat_cnt_nxt;
  logic [CW-1:0] beat_tgt, beat_tgt_nxt;
  logic [SW-1:0] starve_cnt, starve_cnt_nxt;
  logic          starve_hit;
  logic          grant_req;

  // Reserved burst code 11 behaves like a normal single transfer.
  function automatic logic [CW-1:0] tgt_of(input logic [1:0] burst);
    return (burst == 2'b01 || burst == 2'b10) ? TGT_BURST : TGT_SINGLE;
  endfunction

  assign starve_hit = (starve_cnt == STARVE_MAX);
  assign grant_req  = (state == GNT_I) ? I_REQ : D_REQ;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      beat_cnt   <= '0;
      beat_tgt   <= '0;
      starve_cnt <= '0;
    end else begin
      state      <= state_nxt;
      beat_cnt   <= beat_cnt_nxt;
      beat_tgt   <= beat_tgt_nxt;
      starve_cnt <= starve_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    beat_cnt_nxt   = beat_cnt;
    beat_tgt_nxt   = beat_tgt;
    starve_cnt_nxt = starve_cnt;
    case (state)
      IDLE: begin
        if (!I_REQ) starve_cnt_nxt = '0;
        if (D_REQ && !(I_REQ && starve_hit)) begin
          state_nxt    = GNT_D;
          beat_tgt_nxt = tgt_of(D_BURST);
          beat_cnt_nxt = '0;
          // Reaching here with I_REQ high implies the counter is below its limit.
          if (I_REQ) starve_cnt_nxt = starve_cnt + SW'(1);
        end else if (I_REQ) begin
          state_nxt      = GNT_I;
          beat_tgt_nxt   = tgt_of(I_BURST);
          beat_cnt_nxt   = '0;
          starve_cnt_nxt = '0;
        end
      end
      GNT_I, GNT_D: begin
        if (!grant_req) begin
          state_nxt = IDLE;
        end else if (M_ACK) begin
          beat_cnt_nxt = beat_cnt + CW'(1);
          if (beat_cnt_nxt == beat_tgt) state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    M_ADDR    = '0;
    M_BURST   = '0;
    M_REQ     = 1'b0;
    M_WRB     = 1'b0;
    M_WDATA   = '0;
    M_BSTROBE = '0;
    I_RDATA   = '0;
    I_ACK     = 1'b0;
    I_STALL   = 1'b1;
    D_RDATA   = '0;
    D_ACK     = 1'b0;
    D_STALL   = 1'b1;
    case (state)
      GNT_I: begin
        M_ADDR    = I_ADDR;
        M_BURST   = I_BURST;
        M_REQ     = I_REQ;
        M_WRB     = I_WRB;
        M_WDATA   = I_WDATA;
        M_BSTROBE = I_BSTROBE;
        I_RDATA   = M_RDATA;
        I_ACK     = M_ACK;
        I_STALL   = M_STALL;
      end
      GNT_D: begin
        M_ADDR    = D_ADDR;
        M_BURST   = D_BURST;
        M_REQ     = D_REQ;
        M_WRB     = D_WRB;
        M_WDATA   = D_WDATA;
        M_BSTROBE = D_BSTROBE;
        D_RDATA   = M_RDATA;
        D_ACK     = M_ACK;
        D_STALL   = M_STALL;
      end
      default: ;
    endcase
  end

  assign gnt_i = (state == GNT_I);
  assign gnt_d = (state == GNT_D);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: stimulus queues expected grants and acks,
// and a negedge monitor pops and compares them whenever the DUT presents one.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] I_ADDR = '0, D_ADDR = '0, I_WDATA = '0, D_WDATA = '0;
  logic [1:0]  I_BURST = '0, D_BURST = '0;
  logic        I_REQ = 1'b0, D_REQ = 1'b0, I_WRB = 1'b0, D_WRB = 1'b0;
  logic [3:0]  I_BSTROBE = '0, D_BSTROBE = '0;
  logic [31:0] I_RDATA, D_RDATA;
  logic        I_ACK, D_ACK, I_STALL, D_STALL;
  logic [31:0] M_ADDR, M_WDATA;
  logic [1:0]  M_BURST;
  logic        M_REQ, M_WRB;
  logic [3:0]  M_BSTROBE;
  logic [31:0] M_RDATA = '0;
  logic        M_ACK = 1'b0, M_STALL = 1'b0;
  logic        gnt_i, gnt_d;

  mem_port_arbiter #(.BURST_LEN(8), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .I_ADDR(I_ADDR), .I_BURST(I_BURST), .I_REQ(I_REQ), .I_WRB(I_WRB),
    .I_WDATA(I_WDATA), .I_BSTROBE(I_BSTROBE), .I_RDATA(I_RDATA),
    .I_ACK(I_ACK), .I_STALL(I_STALL),
    .D_ADDR(D_ADDR), .D_BURST(D_BURST), .D_REQ(D_REQ), .D_WRB(D_WRB),
    .D_WDATA(D_WDATA), .D_BSTROBE(D_BSTROBE), .D_RDATA(D_RDATA),
    .D_ACK(D_ACK), .D_STALL(D_STALL),
    .M_ADDR(M_ADDR), .M_BURST(M_BURST), .M_REQ(M_REQ), .M_WRB(M_WRB),
    .M_WDATA(M_WDATA), .M_BSTROBE(M_BSTROBE), .M_RDATA(M_RDATA),
    .M_ACK(M_ACK), .M_STALL(M_STALL),
    .gnt_i(gnt_i), .gnt_d(gnt_d)
  );

  always #5 clk = ~clk;

  typedef struct { bit is_d; logic [31:0] addr; } gnt_t;
  typedef struct { bit is_d; logic [31:0] data; } ack_t;

  gnt_t gnt_q[$];
  ack_t ack_q[$];
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // Monitor: a new grant always follows an IDLE bubble, so a rising grant marks a transfer.
  logic prev_gnt = 1'b0;
  always @(negedge clk) begin : mon
    gnt_t g;
    ack_t a;
    chk("gnt_onehot", 32'(gnt_i & gnt_d), 32'd0);
    chk("ack_onehot", 32'(I_ACK & D_ACK), 32'd0);
    if ((gnt_i || gnt_d) && !prev_gnt) begin
      if (gnt_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL grant_unexpected: got gnt_i=%0b gnt_d=%0b expected no grant", gnt_i, gnt_d);
      end else begin
        g = gnt_q.pop_front();
        chk("grant_master_d", 32'(gnt_d), 32'(g.is_d));
        chk("grant_addr", M_ADDR, g.addr);
        chk("grant_mreq", 32'(M_REQ), 32'd1);
      end
    end
    prev_gnt = gnt_i || gnt_d;
    if (I_ACK || D_ACK) begin
      if (ack_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL ack_unexpected: got I_ACK=%0b D_ACK=%0b expected none", I_ACK, D_ACK);
      end else begin
        a = ack_q.pop_front();
        chk("ack_master_d", 32'(D_ACK), 32'(a.is_d));
        chk("ack_rdata", a.is_d ? D_RDATA : I_RDATA, a.data);
        chk("ack_other_rdata", a.is_d ? I_RDATA : D_RDATA, 32'd0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int  beat;
    bit  stall;
    bit  is_d;

    // Reset with requests and a stray ACK present: nothing may leak through.
    #2;
    rst_n = 1'b0; I_REQ = 1'b1; D_REQ = 1'b1; M_ACK = 1'b1;
    M_RDATA = 32'h1234_5678; I_ADDR = 32'hAAAA_0000; D_ADDR = 32'hBBBB_0000;
    settle();
    chk("rst_mreq", 32'(M_REQ), 32'd0);
    chk("rst_maddr", M_ADDR, 32'd0);
    chk("rst_gnt", {30'd0, gnt_i, gnt_d}, 32'd0);
    chk("rst_acks", {30'd0, I_ACK, D_ACK}, 32'd0);
    chk("rst_stalls", {30'd0, I_STALL, D_STALL}, 32'd3);
    chk("rst_rdata", I_RDATA | D_RDATA, 32'd0);
    tick();
    tick();
    chk("rst_hold_gnt", {30'd0, gnt_i, gnt_d}, 32'd0);
    I_REQ = 1'b0; D_REQ = 1'b0; M_ACK = 1'b0;
    rst_n = 1'b1;
    tick();

    // D single read.
    D_ADDR = 32'h0000_1000; D_BURST = 2'b00; D_WRB = 1'b0; D_REQ = 1'b1;
    gnt_q.push_back('{1'b1, 32'h0000_1000});
    tick();
    chk("t1_latency_mreq", 32'(M_REQ), 32'd1);
    chk("t1_gnt_d", 32'(gnt_d), 32'd1);
    chk("t1_i_stall", 32'(I_STALL), 32'd1);
    M_ACK = 1'b1; M_RDATA = 32'hDEAD_BEEF;
    ack_q.push_back('{1'b1, 32'hDEAD_BEEF});
    settle();
    chk("t1_d_ack", 32'(D_ACK), 32'd1);
    chk("t1_d_rdata", D_RDATA, 32'hDEAD_BEEF);
    chk("t1_i_stall_ack", 32'(I_STALL), 32'd1);
    tick();
    D_REQ = 1'b0;
    chk("t1_release_mreq", 32'(M_REQ), 32'd0);
    chk("t1_release_gnt", 32'(gnt_d), 32'd0);
    tick();
    chk("t1_idle_ack_drop", {30'd0, I_ACK, D_ACK}, 32'd0);
    M_ACK = 1'b0;

    // I INCR burst with a two-cycle stall mid-burst.
    I_ADDR = 32'h0000_2000; I_BURST = 2'b01; I_REQ = 1'b1;
    gnt_q.push_back('{1'b0, 32'h0000_2000});
    tick();
    chk("t2_gnt_i", 32'(gnt_i), 32'd1);
    chk("t2_m_burst", 32'(M_BURST), 32'd1);
    chk("t2_d_stall", 32'(D_STALL), 32'd1);
    beat = 0;
    for (int c = 0; c < 10; c++) begin
      stall = (c == 3 || c == 4);
      M_STALL = stall;
      M_ACK = !stall;
      if (!stall) begin
        M_RDATA = 32'hA000_0000 + 32'(beat);
        ack_q.push_back('{1'b0, 32'hA000_0000 + 32'(beat)});
        beat++;
      end
      settle();
      chk("t2_stall_mirror", 32'(I_STALL), 32'(stall));
      chk("t2_grant_held", 32'(gnt_i), 32'd1);
      tick();
    end
    M_ACK = 1'b0; M_STALL = 1'b0; I_REQ = 1'b0;
    chk("t2_release_gnt", 32'(gnt_i), 32'd0);
    chk("t2_release_mreq", 32'(M_REQ), 32'd0);
    tick();

    // Simultaneous requests: D first, one bubble, then I (a single write).
    I_ADDR = 32'h0000_2100; I_BURST = 2'b00; I_WRB = 1'b1;
    I_WDATA = 32'h0000_CAFE; I_BSTROBE = 4'b0011;
    D_ADDR = 32'h0000_3100; D_BURST = 2'b00; D_WRB = 1'b0;
    I_REQ = 1'b1; D_REQ = 1'b1;
    gnt_q.push_back('{1'b1, 32'h0000_3100});
    gnt_q.push_back('{1'b0, 32'h0000_2100});
    tick();
    chk("t3_d_first", {30'd0, gnt_i, gnt_d}, 32'd1);
    chk("t3_i_stalled", 32'(I_STALL), 32'd1);
    M_ACK = 1'b1; M_RDATA = 32'h0000_0033;
    ack_q.push_back('{1'b1, 32'h0000_0033});
    tick();
    D_REQ = 1'b0; M_ACK = 1'b0;
    chk("t3_bubble", {30'd0, gnt_i, gnt_d}, 32'd0);
    tick();
    chk("t3_i_second", {30'd0, gnt_i, gnt_d}, 32'd2);
    chk("t3_m_wdata", M_WDATA, 32'h0000_CAFE);
    chk("t3_m_wrb", 32'(M_WRB), 32'd1);
    chk("t3_m_bstrobe", 32'(M_BSTROBE), 32'd3);
    M_ACK = 1'b1; M_RDATA = 32'h0000_0044;
    ack_q.push_back('{1'b0, 32'h0000_0044});
    tick();
    I_REQ = 1'b0; M_ACK = 1'b0; I_WRB = 1'b0;
    chk("t3_release", 32'(gnt_i), 32'd0);
    tick();

    // Starvation: D held with I pending -> D,D,D,D,I, then D again after the counter clears.
    I_ADDR = 32'h0000_2200; I_BURST = 2'b00;
    D_ADDR = 32'h0000_3200; D_BURST = 2'b00;
    I_REQ = 1'b1; D_REQ = 1'b1;
    for (int r = 0; r < 6; r++) begin
      is_d = (r != 4);
      gnt_q.push_back('{is_d, is_d ? 32'h0000_3200 : 32'h0000_2200});
      tick();
      chk("t4_grant_d", 32'(gnt_d), 32'(is_d));
      M_ACK = 1'b1; M_RDATA = 32'h400 + 32'(r);
      ack_q.push_back('{is_d, 32'h400 + 32'(r)});
      tick();
      M_ACK = 1'b0;
      if (r == 5) begin
        I_REQ = 1'b0; D_REQ = 1'b0;
      end
      chk("t4_bubble", {30'd0, gnt_i, gnt_d}, 32'd0);
    end
    tick();

    // D WRAP aborted after 3 beats; pending I burst must then run all 8 beats.
    D_ADDR = 32'h0000_3300; D_BURST = 2'b10;
    I_ADDR = 32'h0000_2300; I_BURST = 2'b01;
    I_REQ = 1'b1; D_REQ = 1'b1;
    gnt_q.push_back('{1'b1, 32'h0000_3300});
    gnt_q.push_back('{1'b0, 32'h0000_2300});
    tick();
    chk("t5_gnt_d", 32'(gnt_d), 32'd1);
    for (int b = 0; b < 3; b++) begin
      M_ACK = 1'b1; M_RDATA = 32'h500 + 32'(b);
      ack_q.push_back('{1'b1, 32'h500 + 32'(b)});
      tick();
    end
    M_ACK = 1'b0; D_REQ = 1'b0;
    settle();
    chk("t5_still_gnt_d", 32'(gnt_d), 32'd1);
    chk("t5_abort_mreq", 32'(M_REQ), 32'd0);
    tick();
    chk("t5_abort_idle", {30'd0, gnt_i, gnt_d}, 32'd0);
    tick();
    chk("t5_gnt_i", 32'(gnt_i), 32'd1);
    for (int b = 0; b < 8; b++) begin
      chk("t5_i_hold", 32'(gnt_i), 32'd1);
      M_ACK = 1'b1; M_RDATA = 32'h580 + 32'(b);
      ack_q.push_back('{1'b0, 32'h580 + 32'(b)});
      tick();
    end
    M_ACK = 1'b0; I_REQ = 1'b0;
    chk("t5_i_release", 32'(gnt_i), 32'd0);
    tick();

    // Reset mid-burst at beat 4 of 8.
    D_ADDR = 32'h0000_3400; D_BURST = 2'b10; D_REQ = 1'b1;
    gnt_q.push_back('{1'b1, 32'h0000_3400});
    tick();
    for (int b = 0; b < 3; b++) begin
      M_ACK = 1'b1; M_RDATA = 32'h600 + 32'(b);
      ack_q.push_back('{1'b1, 32'h600 + 32'(b)});
      tick();
    end
    M_ACK = 1'b0;
    settle();
    chk("t6_pre_rst_gnt", 32'(gnt_d), 32'd1);
    rst_n = 1'b0;
    settle();
    chk("t6_rst_mreq", 32'(M_REQ), 32'd0);
    chk("t6_rst_gnt_d", 32'(gnt_d), 32'd0);
    chk("t6_rst_d_stall", 32'(D_STALL), 32'd1);
    D_REQ = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    chk("t6_idle_after", {30'd0, gnt_i, gnt_d}, 32'd0);
    I_ADDR = 32'h0000_2400; I_BURST = 2'b00; I_REQ = 1'b1;
    gnt_q.push_back('{1'b0, 32'h0000_2400});
    tick();
    chk("t6_gnt_i", 32'(gnt_i), 32'd1);
    M_ACK = 1'b1; M_RDATA = 32'h0000_0700;
    ack_q.push_back('{1'b0, 32'h0000_0700});
    tick();
    M_ACK = 1'b0; I_REQ = 1'b0;
    chk("t6_i_release", 32'(gnt_i), 32'd0);
    tick();
    tick();

    chk("grant_queue_drained", 32'(gnt_q.size()), 32'd0);
    chk("ack_queue_drained", 32'(ack_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
